// File: rtl/lsu_trigger_commit.sv
// LSU trigger commit: carries dc3 trigger matches through dc4/dc5, applies chaining and flushes,
// and resolves committed hits into debug requests or breakpoint exceptions with sticky status and a hit counter.
module lsu_trigger_commit #(
    parameter int NTRIG = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lsu_pkt_valid_dc3,
    input  logic [NTRIG-1:0]   trig_match_dc3,
    input  logic               stall_dc3,
    input  logic               flush_dc4,
    input  logic               flush_dc5,
    input  logic [NTRIG/2-1:0] trig_chain,
    input  logic [NTRIG-1:0]   trig_action,
    input  logic [NTRIG-1:0]   mhit_clr,
    input  logic               cnt_clr,
    output logic [NTRIG-1:0]   trig_match_dc4,
    output logic [NTRIG-1:0]   trig_hit_dc5,
    output logic               trig_debug_req,
    output logic               trig_bkpt_exc,
    output logic [NTRIG-1:0]   trig_mhit,
    output logic [CNT_W-1:0]   trig_hit_cnt
);

    localparam int NPAIR = NTRIG / 2;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [NTRIG-1:0] m4_p0;
    logic [NTRIG-1:0] chained_p0;
    logic [NTRIG-1:0] h5_p1;
    logic             counted_p1;
    logic [NTRIG-1:0] hit_rec_p1;
    logic             cnt_inc_p1;

    // dc4: pair chaining requires both triggers of a pair to match together
    always_comb begin
        chained_p0 = m4_p0;
        for (int k = 0; k < NPAIR; k++) begin
            if (trig_chain[k]) begin
                chained_p0[2*k]   = m4_p0[2*k] & m4_p0[2*k+1];
                chained_p0[2*k+1] = m4_p0[2*k] & m4_p0[2*k+1];
            end
        end
    end

    assign trig_match_dc4 = chained_p0 & ~{NTRIG{flush_dc4}};

    // dc5: a stalled entry re-presents, but only its first presentation is recorded
    assign trig_hit_dc5   = h5_p1 & ~{NTRIG{flush_dc5}};
    assign trig_debug_req = |(trig_hit_dc5 & trig_action);
    assign trig_bkpt_exc  = (|(trig_hit_dc5 & ~trig_action)) & ~trig_debug_req;
    assign hit_rec_p1     = trig_hit_dc5 & {NTRIG{~counted_p1}};
    assign cnt_inc_p1     = |hit_rec_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            m4_p0        <= '0;
            h5_p1        <= '0;
            counted_p1   <= 1'b0;
            trig_mhit    <= '0;
            trig_hit_cnt <= '0;
        end else begin
            if (!stall_dc3) begin
                m4_p0      <= trig_match_dc3 & {NTRIG{lsu_pkt_valid_dc3}};
                h5_p1      <= trig_match_dc4;
                counted_p1 <= 1'b0;
            end else begin
                if (flush_dc4)
                    m4_p0 <= '0;
                if (flush_dc5) begin
                    h5_p1      <= '0;
                    counted_p1 <= 1'b0;
                end else begin
                    counted_p1 <= 1'b1;
                end
            end
            trig_mhit <= (trig_mhit & ~mhit_clr) | hit_rec_p1;
            if (cnt_inc_p1)
                trig_hit_cnt <= cnt_clr ? CNT_W'(1) : sat_inc(trig_hit_cnt);
            else if (cnt_clr)
                trig_hit_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_lsu_trigger_commit.sv
// Directed self-checking bench for lsu_trigger_commit.
module tb_lsu_trigger_commit;

    logic       clk = 1'b0;
    logic       rst;
    logic       lsu_pkt_valid_dc3;
    logic [3:0] trig_match_dc3;
    logic       stall_dc3;
    logic       flush_dc4;
    logic       flush_dc5;
    logic [1:0] trig_chain;
    logic [3:0] trig_action;
    logic [3:0] mhit_clr;
    logic       cnt_clr;
    logic [3:0] trig_match_dc4;
    logic [3:0] trig_hit_dc5;
    logic       trig_debug_req;
    logic       trig_bkpt_exc;
    logic [3:0] trig_mhit;
    logic [7:0] trig_hit_cnt;

    int tests = 0;
    int fails = 0;

    lsu_trigger_commit #(.NTRIG(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .lsu_pkt_valid_dc3(lsu_pkt_valid_dc3),
        .trig_match_dc3(trig_match_dc3), .stall_dc3(stall_dc3),
        .flush_dc4(flush_dc4), .flush_dc5(flush_dc5), .trig_chain(trig_chain),
        .trig_action(trig_action), .mhit_clr(mhit_clr), .cnt_clr(cnt_clr),
        .trig_match_dc4(trig_match_dc4), .trig_hit_dc5(trig_hit_dc5),
        .trig_debug_req(trig_debug_req), .trig_bkpt_exc(trig_bkpt_exc),
        .trig_mhit(trig_mhit), .trig_hit_cnt(trig_hit_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        lsu_pkt_valid_dc3 = 1'b0;
        trig_match_dc3    = '0;
        stall_dc3         = 1'b0;
        flush_dc4         = 1'b0;
        flush_dc5         = 1'b0;
        trig_chain        = '0;
        trig_action       = '0;
        mhit_clr          = '0;
        cnt_clr           = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        // put matches in flight, then reset before they commit
        lsu_pkt_valid_dc3 = 1'b1;
        trig_match_dc3    = 4'b1111;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        #1;
        tests++;
        if (trig_match_dc4 !== 4'b0000) begin fails++; $display("FAIL reset_dc4: got %b want 0000", trig_match_dc4); end
        tests++;
        if (trig_hit_dc5 !== 4'b0000) begin fails++; $display("FAIL reset_hit: got %b want 0000", trig_hit_dc5); end
        tests++;
        if (trig_debug_req !== 1'b0 || trig_bkpt_exc !== 1'b0) begin
            fails++; $display("FAIL reset_req: got dbg=%b exc=%b want 0 0", trig_debug_req, trig_bkpt_exc);
        end
        tests++;
        if (trig_mhit !== 4'b0000 || trig_hit_cnt !== 8'h00) begin
            fails++; $display("FAIL reset_status: got mhit=%b cnt=%h want 0000 00", trig_mhit, trig_hit_cnt);
        end
        tick();
        tests++;
        if (trig_hit_dc5 !== 4'b0000 || trig_mhit !== 4'b0000) begin
            fails++; $display("FAIL reset_drop: got hit=%b mhit=%b want 0000 0000", trig_hit_dc5, trig_mhit);
        end
    endtask

    task automatic test_basic();
        do_reset();
        lsu_pkt_valid_dc3 = 1'b1;
        trig_match_dc3    = 4'b0001;
        tick();
        trig_match_dc3 = 4'b0000;
        #1;
        tests++;
        if (trig_match_dc4 !== 4'b0001) begin fails++; $display("FAIL basic_dc4: got %b want 0001", trig_match_dc4); end
        tick();
        tests++;
        if (trig_hit_dc5 !== 4'b0001) begin fails++; $display("FAIL basic_hit: got %b want 0001", trig_hit_dc5); end
        tests++;
        if (trig_bkpt_exc !== 1'b1 || trig_debug_req !== 1'b0) begin
            fails++; $display("FAIL basic_exc: got dbg=%b exc=%b want 0 1", trig_debug_req, trig_bkpt_exc);
        end
        tests++;
        if (trig_mhit !== 4'b0000) begin fails++; $display("FAIL basic_mhit_early: got %b want 0000", trig_mhit); end
        tick();
        tests++;
        if (trig_mhit !== 4'b0001 || trig_hit_cnt !== 8'd1) begin
            fails++; $display("FAIL basic_mhit: got mhit=%b cnt=%0d want 0001 1", trig_mhit, trig_hit_cnt);
        end
        // invalid packet must not match
        lsu_pkt_valid_dc3 = 1'b0;
        trig_match_dc3    = 4'b1111;
        tick();
        tests++;
        if (trig_match_dc4 !== 4'b0000) begin fails++; $display("FAIL basic_invalid: got %b want 0000", trig_match_dc4); end
    endtask

    task automatic test_chain();
        do_reset();
        trig_chain        = 2'b01;
        lsu_pkt_valid_dc3 = 1'b1;
        trig_match_dc3    = 4'b0001;
        tick();
        trig_match_dc3 = 4'b0000;
        #1;
        tests++;
        if (trig_match_dc4 !== 4'b0000) begin fails++; $display("FAIL chain_half: got %b want 0000", trig_match_dc4); end
        tick();
        tests++;
        if (trig_hit_dc5 !== 4'b0000) begin fails++; $display("FAIL chain_half_hit: got %b want 0000", trig_hit_dc5); end
        trig_match_dc3 = 4'b0011;
        tick();
        trig_match_dc3 = 4'b0000;
        tick();
        tests++;
        if (trig_hit_dc5 !== 4'b0011) begin fails++; $display("FAIL chain_full_hit: got %b want 0011", trig_hit_dc5); end
        tick();
        tests++;
        if (trig_hit_cnt !== 8'd1) begin fails++; $display("FAIL chain_cnt: got %0d want 1", trig_hit_cnt); end
        // unchained pair 1 passes single bits through
        trig_match_dc3 = 4'b0100;
        tick();
        trig_match_dc3 = 4'b0000;
        #1;
        tests++;
        if (trig_match_dc4 !== 4'b0100) begin fails++; $display("FAIL chain_pass: got %b want 0100", trig_match_dc4); end
    endtask

    task automatic test_action();
        do_reset();
        trig_action       = 4'b0010;
        lsu_pkt_valid_dc3 = 1'b1;
        trig_match_dc3    = 4'b0011;
        tick();
        trig_match_dc3 = 4'b0001;
        tick();
        trig_match_dc3 = 4'b0000;
        #1;
        tests++;
        if (trig_debug_req !== 1'b1 || trig_bkpt_exc !== 1'b0) begin
            fails++; $display("FAIL action_dbg: got dbg=%b exc=%b want 1 0", trig_debug_req, trig_bkpt_exc);
        end
        tick();
        tests++;
        if (trig_debug_req !== 1'b0 || trig_bkpt_exc !== 1'b1) begin
            fails++; $display("FAIL action_exc: got dbg=%b exc=%b want 0 1", trig_debug_req, trig_bkpt_exc);
        end
    endtask

    task automatic test_flush();
        do_reset();
        lsu_pkt_valid_dc3 = 1'b1;
        trig_match_dc3    = 4'b0100;
        tick();
        trig_match_dc3 = 4'b0000;
        flush_dc4      = 1'b1;
        #1;
        tests++;
        if (trig_match_dc4 !== 4'b0000) begin fails++; $display("FAIL flush4_dc4: got %b want 0000", trig_match_dc4); end
        tick();
        flush_dc4 = 1'b0;
        #1;
        tests++;
        if (trig_hit_dc5 !== 4'b0000) begin fails++; $display("FAIL flush4_hit: got %b want 0000", trig_hit_dc5); end
        trig_match_dc3 = 4'b0100;
        tick();
        trig_match_dc3 = 4'b0000;
        tick();
        flush_dc5 = 1'b1;
        #1;
        tests++;
        if (trig_hit_dc5 !== 4'b0000 || trig_bkpt_exc !== 1'b0) begin
            fails++; $display("FAIL flush5_hit: got hit=%b exc=%b want 0000 0", trig_hit_dc5, trig_bkpt_exc);
        end
        tick();
        flush_dc5 = 1'b0;
        tick();
        tests++;
        if (trig_mhit !== 4'b0000 || trig_hit_cnt !== 8'd0) begin
            fails++; $display("FAIL flush5_status: got mhit=%b cnt=%0d want 0000 0", trig_mhit, trig_hit_cnt);
        end
    endtask

    task automatic test_stall();
        do_reset();
        lsu_pkt_valid_dc3 = 1'b1;
        trig_match_dc3    = 4'b1000;
        tick();
        trig_match_dc3 = 4'b0000;
        tick();
        stall_dc3 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (trig_hit_dc5 !== 4'b1000) begin fails++; $display("FAIL stall_hit%0d: got %b want 1000", i, trig_hit_dc5); end
            tick();
        end
        stall_dc3 = 1'b0;
        #1;
        tests++;
        if (trig_hit_cnt !== 8'd1 || trig_mhit !== 4'b1000) begin
            fails++; $display("FAIL stall_once: got cnt=%0d mhit=%b want 1 1000", trig_hit_cnt, trig_mhit);
        end
        tick();
        tests++;
        if (trig_hit_dc5 !== 4'b0000 || trig_hit_cnt !== 8'd1) begin
            fails++; $display("FAIL stall_release: got hit=%b cnt=%0d want 0000 1", trig_hit_dc5, trig_hit_cnt);
        end
        // flush of a stalled dc5 entry is dropped without recording
        trig_match_dc3 = 4'b0001;
        tick();
        trig_match_dc3 = 4'b0000;
        tick();
        stall_dc3 = 1'b1;
        flush_dc5 = 1'b1;
        tick();
        flush_dc5 = 1'b0;
        #1;
        tests++;
        if (trig_hit_dc5 !== 4'b0000) begin fails++; $display("FAIL stall_flush5_hit: got %b want 0000", trig_hit_dc5); end
        tick();
        tests++;
        if (trig_hit_cnt !== 8'd1 || trig_mhit !== 4'b1000) begin
            fails++; $display("FAIL stall_flush5_status: got cnt=%0d mhit=%b want 1 1000", trig_hit_cnt, trig_mhit);
        end
        // flush of a stalled dc4 entry clears it
        stall_dc3      = 1'b0;
        trig_match_dc3 = 4'b0010;
        tick();
        trig_match_dc3 = 4'b0000;
        stall_dc3      = 1'b1;
        flush_dc4      = 1'b1;
        tick();
        flush_dc4 = 1'b0;
        stall_dc3 = 1'b0;
        #1;
        tests++;
        if (trig_match_dc4 !== 4'b0000) begin fails++; $display("FAIL stall_flush4: got %b want 0000", trig_match_dc4); end
    endtask

    task automatic test_saturate();
        do_reset();
        lsu_pkt_valid_dc3 = 1'b1;
        trig_match_dc3    = 4'b0001;
        // continuous hits: count after N edges is N-2
        for (int i = 0; i < 256; i++) tick();
        tests++;
        if (trig_hit_cnt !== 8'hFE) begin fails++; $display("FAIL sat_fe: got %h want FE", trig_hit_cnt); end
        tick();
        tests++;
        if (trig_hit_cnt !== 8'hFF) begin fails++; $display("FAIL sat_ff: got %h want FF", trig_hit_cnt); end
        tick();
        tick();
        tests++;
        if (trig_hit_cnt !== 8'hFF) begin fails++; $display("FAIL sat_hold: got %h want FF", trig_hit_cnt); end
        mhit_clr = 4'b0001;
        cnt_clr  = 1'b1;
        tick();
        mhit_clr = 4'b0000;
        cnt_clr  = 1'b0;
        tests++;
        if (trig_mhit !== 4'b0001) begin fails++; $display("FAIL mhit_set_wins: got %b want 0001", trig_mhit); end
        tests++;
        if (trig_hit_cnt !== 8'd1) begin fails++; $display("FAIL cnt_inc_wins: got %0d want 1", trig_hit_cnt); end
        trig_match_dc3 = 4'b0000;
        tick();
        tick();
        mhit_clr = 4'b0001;
        cnt_clr  = 1'b1;
        tick();
        mhit_clr = 4'b0000;
        cnt_clr  = 1'b0;
        tests++;
        if (trig_mhit !== 4'b0000 || trig_hit_cnt !== 8'd0) begin
            fails++; $display("FAIL clear: got mhit=%b cnt=%0d want 0000 0", trig_mhit, trig_hit_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_chain();
        test_action();
        test_flush();
        test_stall();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
